// File: rtl/control_unit.sv
// control_unit
//   Main decoder for the single-issue 32-bit CPU datapath. Maps the 6-bit
//   instruction opcode (instr[31:26]) to datapath control strobes and a
//   6-bit ALU operation code. All outputs are registered, so there is one
//   cycle of latency from opcode to controls and no combinational path from
//   opcode to any output.
//
//   A HALT opcode sets a sticky halted flag. While the flag is set, the
//   outputs are forced to the HALT pattern (all zero, PC frozen) whatever the
//   opcode is. Only reset clears the flag.
//
// Ports
//   clk         in   1  rising-edge clock
//   rst_n       in   1  synchronous active-low reset (all outputs to 0)
//   opcode      in   6  instr[31:26]
//   pc_src      out  2  00 PC+4, 01 BEQ target, 10 jump target, 11 BNE target
//   reg_src     out  1  writeback source: 0 ALU result, 1 memory data
//   reg_dst     out  1  destination register: 0 rt, 1 rd
//   alu_src1    out  1  ALU A operand: 0 rs, 1 zero-extended shamt
//   alu_src2    out  1  ALU B operand: 0 rt, 1 extended immediate
//   reg_write   out  1  register file write enable
//   mem_word    out  1  memory access size: 1 word, 0 byte
//   mem_write   out  1  data memory write strobe
//   mem_read    out  1  data memory read strobe
//   pc_enable   out  1  PC update enable
//   alu_opcode  out  6  ALU operation code
module control_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  output logic [1:0] pc_src,
  output logic       reg_src,
  output logic       reg_dst,
  output logic       alu_src1,
  output logic       alu_src2,
  output logic       reg_write,
  output logic       mem_word,
  output logic       mem_write,
  output logic       mem_read,
  output logic       pc_enable,
  output logic [5:0] alu_opcode
);

  // Instruction opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_SLLI  = 6'b011001;
  localparam logic [5:0] OP_SRLI  = 6'b011100;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  // ALU operation codes
  localparam logic [5:0] ALU_ADD   = 6'b000000;
  localparam logic [5:0] ALU_SUB   = 6'b000001;
  localparam logic [5:0] ALU_AND   = 6'b000010;
  localparam logic [5:0] ALU_OR    = 6'b000011;
  localparam logic [5:0] ALU_XOR   = 6'b000100;
  localparam logic [5:0] ALU_SLT   = 6'b000101;
  localparam logic [5:0] ALU_SLL   = 6'b000110;
  localparam logic [5:0] ALU_SRL   = 6'b000111;
  localparam logic [5:0] ALU_PASSB = 6'b001000;
  localparam logic [5:0] ALU_FUNCT = 6'b111111;

  localparam logic [1:0] PC_NEXT = 2'b00;
  localparam logic [1:0] PC_BEQ  = 2'b01;
  localparam logic [1:0] PC_JUMP = 2'b10;
  localparam logic [1:0] PC_BNE  = 2'b11;

  typedef struct packed {
    logic [1:0] pc_src;
    logic       reg_src;
    logic       reg_dst;
    logic       alu_src1;
    logic       alu_src2;
    logic       reg_write;
    logic       mem_word;
    logic       mem_write;
    logic       mem_read;
    logic       pc_enable;
    logic [5:0] alu_opcode;
  } ctrl_t;

  typedef enum logic {
    ST_RUN,
    ST_HALTED
  } state_e;

  state_e state, next_state;
  ctrl_t  ctrl_q, ctrl_d;

  // Next-state and decode. The all-zero struct doubles as the HALT pattern.
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    next_state        = state;
    ctrl_d            = '0;
    ctrl_d.pc_enable  = 1'b1;
    ctrl_d.pc_src     = PC_NEXT;
    ctrl_d.alu_opcode = ALU_ADD;

    case (opcode)
      OP_RTYPE: begin
        ctrl_d.reg_dst    = 1'b1;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.alu_opcode = ALU_FUNCT;
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        ctrl_d.alu_src2  = 1'b1;
        ctrl_d.reg_write = 1'b1;
        case (opcode)
          OP_SLTI: ctrl_d.alu_opcode = ALU_SLT;
          OP_ANDI: ctrl_d.alu_opcode = ALU_AND;
          OP_ORI:  ctrl_d.alu_opcode = ALU_OR;
          OP_XORI: ctrl_d.alu_opcode = ALU_XOR;
          OP_LUI:  ctrl_d.alu_opcode = ALU_PASSB;
          default: ctrl_d.alu_opcode = ALU_ADD;
        endcase
      end
      OP_J:   ctrl_d.pc_src = PC_JUMP;
      OP_BEQ: begin
        ctrl_d.pc_src     = PC_BEQ;
        ctrl_d.alu_opcode = ALU_SUB;
      end
      OP_BNE: begin
        ctrl_d.pc_src     = PC_BNE;
        ctrl_d.alu_opcode = ALU_SUB;
      end
      OP_SLLI, OP_SRLI: begin
        // Shift-immediate: the shift amount is fed to ALU A from shamt.
        ctrl_d.alu_src1   = 1'b1;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.alu_opcode = (opcode == OP_SLLI) ? ALU_SLL : ALU_SRL;
      end
      OP_LB, OP_LW: begin
        ctrl_d.alu_src2  = 1'b1;
        ctrl_d.mem_read  = 1'b1;
        ctrl_d.reg_src   = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.mem_word  = (opcode == OP_LW);
      end
      OP_SB, OP_SW: begin
        ctrl_d.alu_src2  = 1'b1;
        ctrl_d.mem_write = 1'b1;
        ctrl_d.mem_word  = (opcode == OP_SW);
      end
      default: ; // undefined opcodes fall through as NOP (defaults above)
    endcase

    // The HALT instruction itself and every cycle after it emit the HALT pattern.
    if (state == ST_HALTED || opcode == OP_HALT) begin
      ctrl_d     = '0;
      next_state = ST_HALTED;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled at the same edge.
    if (!rst_n) begin
      state  <= ST_RUN;
      ctrl_q <= '0;
    end else begin
      state  <= next_state;
      ctrl_q <= ctrl_d;
    end
  end

  assign pc_src     = ctrl_q.pc_src;
  assign reg_src    = ctrl_q.reg_src;
  assign reg_dst    = ctrl_q.reg_dst;
  assign alu_src1   = ctrl_q.alu_src1;
  assign alu_src2   = ctrl_q.alu_src2;
  assign reg_write  = ctrl_q.reg_write;
  assign mem_word   = ctrl_q.mem_word;
  assign mem_write  = ctrl_q.mem_write;
  assign mem_read   = ctrl_q.mem_read;
  assign pc_enable  = ctrl_q.pc_enable;
  assign alu_opcode = ctrl_q.alu_opcode;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit
//   Self-checking bench for control_unit. Each step drives rst_n/opcode on
//   the falling edge, pushes the expected control word onto a scoreboard
//   queue, and pops/compares it just after the following rising edge.
//   Control word layout (17 bits, MSB first):
//   pc_src[1:0] reg_src reg_dst alu_src1 alu_src2 reg_write mem_word
//   mem_write mem_read pc_enable alu_opcode[5:0]
module tb_control_unit;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic [1:0] pc_src;
  logic       reg_src, reg_dst, alu_src1, alu_src2, reg_write;
  logic       mem_word, mem_write, mem_read, pc_enable;
  logic [5:0] alu_opcode;

  control_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .pc_src     (pc_src),
    .reg_src    (reg_src),
    .reg_dst    (reg_dst),
    .alu_src1   (alu_src1),
    .alu_src2   (alu_src2),
    .reg_write  (reg_write),
    .mem_word   (mem_word),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .pc_enable  (pc_enable),
    .alu_opcode (alu_opcode)
  );

  // Rising edges at 10, 20, 30 ... ns; inputs change on falling edges.
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  logic [16:0] observed;
  assign observed = {pc_src, reg_src, reg_dst, alu_src1, alu_src2, reg_write,
                     mem_word, mem_write, mem_read, pc_enable, alu_opcode};

  int          total = 0;
  int          bad   = 0;
  logic [16:0] sb_q[$];
  logic [16:0] last_exp;
  logic        model_halted;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference decode table, written directly from the instruction list.
  //                           pc rs rd a1 a2 rw mw mW mR pe alu
  function automatic logic [16:0] ref_decode(input logic [5:0] op);
    case (op)
      6'b000000: return {2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'b111111};
      6'b000001: return {2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000000};
      6'b000010: return {2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000000};
      6'b000100: return {2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000001};
      6'b000101: return {2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000001};
      6'b001010: return {2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000101};
      6'b001100: return {2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000010};
      6'b001101: return {2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000011};
      6'b001110: return {2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000100};
      6'b001111: return {2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'b001000};
      6'b011001: return {2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000110};
      6'b011100: return {2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000111};
      6'b100000: return {2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'b000000};
      6'b100011: return {2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 6'b000000};
      6'b101000: return {2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'b000000};
      6'b101011: return {2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'b000000};
      6'b111111: return 17'h0;
      default:   return {2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000000};
    endcase
  endfunction

  // One clock of stimulus: drive, predict, then compare after the edge.
  task automatic step(input logic rst, input logic [5:0] op);
    logic [16:0] exp;
    @(negedge clk);
    rst_n  = rst;
    opcode = op;
    if (!rst) begin
      exp          = 17'h0;
      model_halted = 1'b0;
    end else if (model_halted || op == 6'b111111) begin
      exp          = 17'h0;
      model_halted = 1'b1;
    end else begin
      exp = ref_decode(op);
    end
    sb_q.push_back(exp);
    // Outputs must not follow the new opcode before the clock edge.
    if (total > 0) begin
      #1;
      check($sformatf("hold rst=%b op=%b", rst, op), {15'h0, observed}, {15'h0, last_exp});
    end
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("scoreboard empty", 32'd0, 32'd1);
    end else begin
      exp = sb_q.pop_front();
      check($sformatf("ctrl rst=%b op=%b", rst, op), {15'h0, observed}, {15'h0, exp});
      last_exp = exp;
    end
    check("mem rd&wr exclusive", {31'h0, mem_read & mem_write}, 32'd0);
    check("mem_write no reg_write", {31'h0, mem_write & reg_write}, 32'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    opcode       = 6'b000000;
    model_halted = 1'b0;
    last_exp     = 17'h0;

    // Reset held two cycles
    step(1'b0, 6'b000000);
    step(1'b0, 6'b000000);

    // Directed decode sequence
    step(1'b1, 6'b000101); // BNE
    step(1'b1, 6'b101011); // SW
    step(1'b1, 6'b000000); // R-type
    step(1'b1, 6'b000001); // ADDI
    step(1'b1, 6'b011001); // SLLI
    step(1'b1, 6'b011100); // SRLI
    step(1'b1, 6'b100011); // LW
    step(1'b1, 6'b100000); // LB
    step(1'b1, 6'b101000); // SB
    step(1'b1, 6'b000010); // J
    step(1'b1, 6'b000100); // BEQ
    step(1'b1, 6'b001010); // SLTI
    step(1'b1, 6'b001100); // ANDI
    step(1'b1, 6'b001101); // ORI
    step(1'b1, 6'b001110); // XORI
    step(1'b1, 6'b001111); // LUI
    step(1'b1, 6'b010101); // undefined -> NOP

    // Reset mid-stream wins over a valid opcode, then the first edge decodes
    step(1'b0, 6'b100011);
    step(1'b1, 6'b100011);

    // HALT is sticky until reset
    step(1'b1, 6'b111111);
    step(1'b1, 6'b000000);
    step(1'b1, 6'b000001);
    step(1'b1, 6'b101011);
    step(1'b0, 6'b000000);
    step(1'b1, 6'b000000);

    // Random opcodes with occasional resets
    for (int i = 0; i < 60; i++) begin
      step(($urandom_range(0, 15) != 0), 6'($urandom_range(0, 63)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
